// File: rtl/guess_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : guess_pkg                                                    |
// | Description : Shared state encoding and helpers for the guess game core.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package guess_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        WIN  = 3'd2,
        LOSE = 3'd3,
        OVER = 3'd4
    } state_t;

    function automatic int clamp_level(input int lvl, input int n_levels);
        return (lvl >= n_levels) ? n_levels - 1 : lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/guess_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : guess_tick_gen                                               |
// | Description : Prescaler emitting a one-cycle tick every 2^(DIV_W-SHIFT*lvl)|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module guess_tick_gen #(
    parameter  int DIV_W       = 25,
    parameter  int N_LEVELS    = 4,
    parameter  int LEVEL_SHIFT = 2,
    localparam int LVL_W       = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [LVL_W-1:0] lvl,
    output logic             tick
);

    localparam logic [DIV_W-1:0] c_ALL_ONES = {DIV_W{1'b1}};

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    // Terminal count P-1 is simply the all-ones value shortened by the level shift.
    assign w_last = c_ALL_ONES >> (LEVEL_SHIFT * int'(lvl));
    assign tick   = (r_cnt == w_last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/guess_game_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : guess_game_core                                              |
// | Description : Rotating one-hot target game with score, lives and levels.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
import guess_pkg::*;

module guess_game_core #(
    parameter  int N_CH        = 4,
    parameter  int DIV_W       = 25,
    parameter  int N_LEVELS    = 4,
    parameter  int LEVEL_SHIFT = 2,
    parameter  int SCORE_W     = 8,
    parameter  int LIVES       = 3,
    parameter  int HOLD_TICKS  = 2,
    localparam int LVL_W       = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    btn,
    input  logic [LVL_W-1:0]   level_sel,
    output logic [N_CH-1:0]    y,
    output logic               win,
    output logic               lose,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives_left,
    output logic [2:0]         state_o
);

    localparam logic [STATE_W-1:0] c_IDLE = IDLE;
    localparam logic [STATE_W-1:0] c_RUN  = RUN;
    localparam logic [STATE_W-1:0] c_WIN  = WIN;
    localparam logic [STATE_W-1:0] c_LOSE = LOSE;
    localparam logic [STATE_W-1:0] c_OVER = OVER;

    localparam int               HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [N_CH-1:0]  c_Y_FIRST = N_CH'(1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [N_CH-1:0]    r_y;
    logic [N_CH-1:0]    r_btn_q;
    logic [N_CH-1:0]    w_press;
    logic [LVL_W-1:0]   r_lvl;
    logic [LVL_W-1:0]   w_lvl_sel;
    logic [HOLD_W-1:0]  r_hold;
    logic [SCORE_W-1:0] r_score;
    logic [3:0]         r_lives;
    logic               w_tick;
    logic               w_hold_done;

    assign w_press     = btn & ~r_btn_q;
    assign w_lvl_sel   = LVL_W'(clamp_level(int'(level_sel), N_LEVELS));
    assign w_hold_done = w_tick && (r_hold == c_HOLD_LAST);

    // Every state change restarts the prescaler, so RUN shifts and hold periods
    // are both measured from the moment of entry.
    guess_tick_gen #(
        .DIV_W       (DIV_W),
        .N_LEVELS    (N_LEVELS),
        .LEVEL_SHIFT (LEVEL_SHIFT)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (w_next != r_state),
        .lvl   (r_lvl),
        .tick  (w_tick)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (w_press != '0) w_next = c_RUN;
            c_RUN: begin
                if (w_press == r_y)       w_next = c_WIN;
                else if (w_press != '0)   w_next = c_LOSE;
            end
            c_WIN:  if (w_hold_done) w_next = c_RUN;
            c_LOSE: if (w_hold_done) w_next = (r_lives == 4'd0) ? c_OVER : c_RUN;
            c_OVER: w_next = c_OVER;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_y     <= '0;
            r_btn_q <= '0;
            r_lvl   <= '0;
            r_hold  <= '0;
            r_score <= '0;
            r_lives <= 4'(LIVES);
        end else begin
            r_state <= w_next;
            r_btn_q <= btn;
            case (r_state)
                c_IDLE: begin
                    if (w_next == c_RUN) begin
                        r_y   <= c_Y_FIRST;
                        r_lvl <= w_lvl_sel;
                    end
                end
                c_RUN: begin
                    // A press wins over a coincident tick: the shift is dropped.
                    if (w_next == c_WIN) begin
                        r_y    <= '1;
                        r_hold <= '0;
                        if (r_score != '1) r_score <= r_score + 1'b1;
                    end else if (w_next == c_LOSE) begin
                        r_y     <= '0;
                        r_hold  <= '0;
                        r_lives <= r_lives - 1'b1;
                    end else if (w_tick) begin
                        r_y <= {r_y[N_CH-2:0], r_y[N_CH-1]};
                    end
                end
                c_WIN, c_LOSE: begin
                    if (w_next == c_RUN) begin
                        r_y   <= c_Y_FIRST;
                        r_lvl <= w_lvl_sel;
                    end else if (w_next == c_OVER) begin
                        r_y <= '0;
                    end else if (w_tick) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_y <= '0;
            endcase
        end
    end

    assign y          = r_y;
    assign win        = (r_state == c_WIN);
    assign lose       = (r_state == c_LOSE);
    assign game_over  = (r_state == c_OVER);
    assign score      = r_score;
    assign lives_left = r_lives;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_guess_game_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_guess_game_core                                           |
// | Description : Scoreboard bench for guess_game_core with directed vectors.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_guess_game_core;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_WIN  = 3'd2;
    localparam logic [2:0] S_LOSE = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    typedef struct packed {
        int         cyc;
        logic [3:0] y;
        logic [2:0] st;
        logic [7:0] score;
        logic [3:0] lives;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [1:0] level_sel;
    logic [3:0] y;
    logic       win, lose, game_over;
    logic [7:0] score;
    logic [3:0] lives_left;
    logic [2:0] state_o;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    string name_q[$];
    exp_t mon_e;
    string mon_n;
    logic [7:0] m_score = 8'd0;
    logic [3:0] m_lives = 4'd2;

    guess_game_core #(
        .N_CH(4), .DIV_W(6), .N_LEVELS(3), .LEVEL_SHIFT(2),
        .SCORE_W(8), .LIVES(2), .HOLD_TICKS(2)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .level_sel(level_sel),
        .y(y), .win(win), .lose(lose), .game_over(game_over),
        .score(score), .lives_left(lives_left), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_at(input int c, input string nm, input logic [3:0] ey, input logic [2:0] est);
        exp_t e;
        e.cyc   = c;
        e.y     = ey;
        e.st    = est;
        e.score = m_score;
        e.lives = m_lives;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the queue head once the DUT reaches the cycle it names.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            checks++;
            if (mon_e.cyc != cyc || y !== mon_e.y || state_o !== mon_e.st ||
                win !== (mon_e.st == S_WIN) || lose !== (mon_e.st == S_LOSE) ||
                game_over !== (mon_e.st == S_OVER) || score !== mon_e.score ||
                lives_left !== mon_e.lives) begin
                failures++;
                $display("FAIL %s: cyc=%0d got y=%b st=%0d win=%b lose=%b over=%b score=%0d lives=%0d ; want cyc=%0d y=%b st=%0d score=%0d lives=%0d",
                         mon_n, cyc, y, state_o, win, lose, game_over, score, lives_left,
                         mon_e.cyc, mon_e.y, mon_e.st, mon_e.score, mon_e.lives);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: cyc=%0d pending=%0d required=0", cyc, exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, w0, x0, l0, y0, l2, e2;
        reset = 1'b1;
        btn = 4'b0000;
        level_sel = 2'd0;
        step(3);
        reset = 1'b0;
        expect_at(cyc, "reset_idle", 4'b0000, S_IDLE);
        step(1);
        expect_at(cyc, "idle_no_press", 4'b0000, S_IDLE);

        // Start at level 0: period 64
        btn = 4'b0100; step(1); btn = 4'b0000;
        e0 = cyc;
        expect_at(e0,       "start_run",  4'b0001, S_RUN);
        expect_at(e0 + 63,  "lvl0_before", 4'b0001, S_RUN);
        expect_at(e0 + 64,  "lvl0_shift1", 4'b0010, S_RUN);
        expect_at(e0 + 128, "lvl0_shift2", 4'b0100, S_RUN);
        goto(e0 + 128);

        // Correct press on y=0100
        btn = 4'b0100; step(1); btn = 4'b0000;
        w0 = cyc;
        m_score = 8'd1;
        level_sel = 2'd2;
        expect_at(w0,       "win_enter", 4'b1111, S_WIN);
        expect_at(w0 + 127, "win_hold",  4'b1111, S_WIN);
        x0 = w0 + 128;
        expect_at(x0,      "win_exit",   4'b0001, S_RUN);
        expect_at(x0 + 3,  "lvl2_pre",   4'b0001, S_RUN);
        expect_at(x0 + 4,  "lvl2_s1",    4'b0010, S_RUN);
        expect_at(x0 + 8,  "lvl2_s2",    4'b0100, S_RUN);
        expect_at(x0 + 12, "lvl2_s3",    4'b1000, S_RUN);
        expect_at(x0 + 16, "lvl2_wrap",  4'b0001, S_RUN);
        expect_at(x0 + 20, "lvl2_s5",    4'b0010, S_RUN);
        goto(x0 + 20);

        // Wrong press btn[0] while y=0010
        btn = 4'b0001; step(1); btn = 4'b0000;
        l0 = cyc;
        m_lives = 4'd1;
        level_sel = 2'd3;
        expect_at(l0,     "lose_enter", 4'b0000, S_LOSE);
        expect_at(l0 + 7, "lose_hold",  4'b0000, S_LOSE);
        y0 = l0 + 8;
        expect_at(y0,     "lose_exit",  4'b0001, S_RUN);
        expect_at(y0 + 3, "clamp_pre",  4'b0001, S_RUN);
        expect_at(y0 + 4, "clamp_s1",   4'b0010, S_RUN);
        expect_at(y0 + 8, "clamp_s2",   4'b0100, S_RUN);
        goto(y0 + 8);

        // Two buttons at once: last life lost, then game over
        btn = 4'b0011; step(1); btn = 4'b0000;
        l2 = cyc;
        m_lives = 4'd0;
        expect_at(l2,     "lose2_enter", 4'b0000, S_LOSE);
        expect_at(l2 + 7, "lose2_hold",  4'b0000, S_LOSE);
        expect_at(l2 + 8, "over_enter",  4'b0000, S_OVER);
        goto(l2 + 8);
        btn = 4'b0100; step(1); btn = 4'b0000;
        step(2);
        btn = 4'b0001; step(1); btn = 4'b0000;
        expect_at(cyc, "over_frozen", 4'b0000, S_OVER);

        // Reset out of OVER
        reset = 1'b1; step(1); reset = 1'b0;
        m_score = 8'd0;
        m_lives = 4'd2;
        expect_at(cyc, "reset_from_over", 4'b0000, S_IDLE);
        step(1);

        // Press coincident with the first tick at level 2
        level_sel = 2'd2;
        btn = 4'b0001; step(1); btn = 4'b0000;
        e2 = cyc;
        expect_at(e2, "start_run2", 4'b0001, S_RUN);
        goto(e2 + 3);
        btn = 4'b0001;
        step(1);
        m_score = 8'd1;
        expect_at(e2 + 4,  "tick_press_win", 4'b1111, S_WIN);
        expect_at(e2 + 11, "tick_win_hold",  4'b1111, S_WIN);
        expect_at(e2 + 12, "tick_win_exit",  4'b0001, S_RUN);
        expect_at(e2 + 13, "held_no_rescore", 4'b0001, S_RUN);
        goto(e2 + 13);
        btn = 4'b0000;
        step(1);
        btn = 4'b0001; step(1);
        m_score = 8'd2;
        expect_at(cyc, "win_again", 4'b1111, S_WIN);

        // Reset during WIN
        reset = 1'b1; btn = 4'b0000; step(1); reset = 1'b0;
        m_score = 8'd0;
        m_lives = 4'd2;
        expect_at(cyc, "reset_from_win", 4'b0000, S_IDLE);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
            failures += exp_q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/guess_game_core.md
Name: guess_game_core

Overview:
- Parametrised successor to the 4-button reaction-guess FSM. It rotates a one-hot "target" across N_CH positions and scores correct button presses.
- Replaces the derived slow clock with a single-clock design: an internal prescaler produces a step-enable tick whose period is selected by a difficulty level.
- Adds a score counter, a lives budget, and a terminal game-over state.
- Sits between the button debouncers and the LED/anode drivers in the top level.

Parameters:
- N_CH, 4: number of buttons and target positions (>=2).
- DIV_W, 25: prescaler width; the level-0 tick period is 2^DIV_W clk cycles.
- N_LEVELS, 4: number of difficulty levels.
- LEVEL_SHIFT, 2: each level divides the tick period by 2^LEVEL_SHIFT. Requires DIV_W > LEVEL_SHIFT*(N_LEVELS-1).
- SCORE_W, 8: score counter width.
- LIVES, 3: wrong presses allowed before game over (1..15).
- HOLD_TICKS, 2: ticks the WIN/LOSE indication is held.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn  in  N_CH  debounced button levels, active-high
- level_sel  in  $clog2(N_LEVELS)  difficulty level; 0 = slowest
- y  out  N_CH  one-hot target position; all-zero when not running
- win  out  1  high for the whole WIN state
- lose  out  1  high for the whole LOSE state
- game_over  out  1  high in the OVER state
- score  out  SCORE_W  correct-press count
- lives_left  out  4  remaining lives
- state_o  out  3  current state encoding, for debug

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: state=IDLE, y=0, win=0, lose=0, game_over=0, score=0, lives_left=LIVES, prescaler=0, btn_q=0.
- Press detection: press = btn & ~btn_q. btn_q is registered every cycle, so only rising edges count. A held button never re-triggers.
- Tick generation:
  - The prescaler counts up every clk.
  - tick is a 1-cycle pulse when prescaler == P-1, where P = 2^(DIV_W - LEVEL_SHIFT*lvl). The prescaler then reloads to 0.
  - lvl is level_sel latched on each entry to RUN. Values >= N_LEVELS clamp to N_LEVELS-1.
  - The prescaler clears to 0 on every entry to RUN, so the first shift occurs exactly P cycles after entry.
- IDLE:
  - y=0.
  - Any nonzero press -> RUN with y=1 (bit 0). The starting press is not scored.
- RUN:
  - On tick, y rotates left (bit N_CH-1 wraps to bit 0).
  - press == y (exactly one bit, matching) -> WIN next cycle; score += 1, saturating at all-ones.
  - press != 0 and press != y (wrong bit, or several bits at once) -> LOSE next cycle; lives_left -= 1.
  - If press and tick occur in the same cycle, press is compared against y before the shift. The shift is then suppressed.
- WIN / LOSE:
  - y is driven all-ones during WIN and all-zero during LOSE.
  - The state is held for HOLD_TICKS ticks, counted from a prescaler cleared on entry. Presses are ignored.
  - On exit, the next state is RUN with y=1 and level_sel re-latched.
  - If lives_left == 0 on LOSE exit, the next state is OVER instead.
- OVER:
  - y=0 and game_over=1. score and lives_left are frozen.
  - Only reset leaves this state.
- Reset mid-game: reset asserted in any state forces all reset values on the next edge. It takes priority over press and tick.
- State encoding: IDLE=0, RUN=1, WIN=2, LOSE=3, OVER=4.

Decomposition:
- Package guess_pkg holds:
  - the state_t enum (IDLE, RUN, WIN, LOSE, OVER);
  - the function clamp_level;
  - the constant STATE_W=3.
- Sub-module guess_tick_gen (parameters DIV_W, N_LEVELS, LEVEL_SHIFT; ports clk, reset, clear, lvl, tick) contains the prescaler and period selection.
- The FSM, score and lives logic stay in guess_game_core.

Test Plan (DIV_W=6, LEVEL_SHIFT=2, N_LEVELS=3, N_CH=4, LIVES=2, HOLD_TICKS=2):
- Reset, then pulse btn[2] -> RUN with y=0001 and score=0. With level_sel=0, y becomes 0010 exactly 64 cycles after RUN entry and 0100 after 128 cycles.
- level_sel=2 (period 4): y walks 0001→0010→0100→1000→0001 every 4 cycles. Setting level_sel=3 behaves identically (clamped).
- In RUN with y=0100, pulse btn[2] -> win=1 and y=1111 for 2 ticks, score=1, then RUN with y=0001.
- Pulse btn[0] while y=0010 -> lose=1 and lives_left=1. Then press btn[0]|btn[1] together -> lose, lives_left=0, then OVER with game_over=1. Further presses leave score unchanged.
- Press the correct button in the same cycle as tick -> WIN, with no shift beforehand. Holding the button through to RUN does not score twice.
- Assert reset during WIN and during OVER -> next edge gives IDLE, y=0, score=0, lives_left=2, win=0, game_over=0.
